// File: rtl/addr_map_pkg.sv
// Shared memory-map definitions: FSM state encoding and the default region windows
// used by both the CPU top and the address decoder.
package addr_map_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int WAIT_W = 4;

  // Region 0 is the least significant slice of each packed vector.
  localparam logic [4*32-1:0] DEF_REGION_BASE  = {32'h0, 32'h0, 32'h0000_0B80, 32'h0000_0780};
  localparam logic [4*32-1:0] DEF_REGION_LIMIT = {32'h0, 32'h0, 32'h0000_0B8F, 32'h0000_0B7F};
  localparam logic [4*WAIT_W-1:0] DEF_REGION_WAIT = {4'd0, 4'd0, 4'd2, 4'd0};

endpackage

// File: rtl/addr_region_match.sv
// Combinational window compare for every region plus a lowest-index-wins priority
// encoder; yields hit, a one-hot select and the winning region index.
module addr_region_match #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = '0
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic                   hit,
  output logic [NUM_REGIONS-1:0] sel,
  output logic [IDX_W-1:0]       idx
);

  logic [NUM_REGIONS-1:0] in_win;

  // A window with base > limit can never satisfy both bounds, so it is disabled.
  always_comb begin
    in_win = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      in_win[k] = (addr >= REGION_BASE[k*ADDR_W +: ADDR_W]) &&
                  (addr <= REGION_LIMIT[k*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    hit = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (in_win[k]) begin
        hit    = 1'b1;
        sel    = '0;
        sel[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/addr_window_decoder.sv
// CPU data-port address decoder: selects one slave window, inserts its wait
// states, returns read data with a one-cycle response pulse and counts unmapped hits.
module addr_window_decoder
  import addr_map_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT  = DEF_REGION_WAIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  input  logic                          req_we,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  output logic                          req_ready,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_err,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic [NUM_REGIONS-1:0]        we,
  output logic [ADDR_W-1:0]             local_addr,
  output logic [DATA_W-1:0]             local_wdata,
  input  logic [NUM_REGIONS*DATA_W-1:0] region_rdata,
  output logic [15:0]                   err_count,
  output state_e                        dbg_state
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  state_e                   state;
  logic [WAIT_W-1:0]        wait_cnt;
  logic [IDX_W-1:0]         cur_idx;
  logic                     cur_we;

  logic                     match_hit;
  logic [NUM_REGIONS-1:0]   match_sel;
  logic [IDX_W-1:0]         match_idx;
  logic [ADDR_W-1:0]        hit_base;
  logic [WAIT_W-1:0]        hit_wait;
  logic [DATA_W-1:0]        rd_sel;

  addr_region_match #(
    .NUM_REGIONS  (NUM_REGIONS),
    .ADDR_W       (ADDR_W),
    .IDX_W        (IDX_W),
    .REGION_BASE  (REGION_BASE),
    .REGION_LIMIT (REGION_LIMIT)
  ) u_match (
    .addr (req_addr),
    .hit  (match_hit),
    .sel  (match_sel),
    .idx  (match_idx)
  );

  always_comb begin
    hit_base = '0;
    hit_wait = '0;
    rd_sel   = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (match_idx == IDX_W'(k)) begin
        hit_base = REGION_BASE[k*ADDR_W +: ADDR_W];
        hit_wait = REGION_WAIT[k*WAIT_W +: WAIT_W];
      end
      if (cur_idx == IDX_W'(k)) begin
        rd_sel = region_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Handshake: a request transfers on a clk edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the CPU holds its request until then.
  // The access completes with resp_valid high for exactly one cycle.
  assign req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cur_idx     <= '0;
      cur_we      <= 1'b0;
      cs          <= '0;
      we          <= '0;
      local_addr  <= '0;
      local_wdata <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (match_hit) begin
              cs          <= match_sel;
              we          <= req_we ? match_sel : '0;
              local_addr  <= req_addr - hit_base;
              local_wdata <= req_wdata;
              wait_cnt    <= hit_wait;
              cur_idx     <= match_idx;
              cur_we      <= req_we;
              state       <= ACCESS;
            end else begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= RESP;
            end
          end
        end
        ACCESS: begin
          // Single write strobe: we only survives the first ACCESS cycle.
          we <= '0;
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else begin
            resp_rdata <= cur_we ? '0 : rd_sel;
            cs         <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addr_window_decoder.sv
// Directed bench for addr_window_decoder: default memory map plus an overlapping-window
// instance, table-driven accesses and hand-written reset/saturation/RESP sequences.
module tb_addr_window_decoder;
  import addr_map_pkg::*;

  typedef struct {
    logic        ov;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_cs;
    logic [31:0] exp_local;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_we = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [127:0] region_rdata = {32'h5A5A_0003, 32'hA5A5_0002, 32'hCAFE_F00D, 32'hDEAD_BEEF};
  logic         use_ov = 1'b0;

  logic         m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0]  m_resp_rdata, m_local_addr, m_local_wdata;
  logic [3:0]   m_cs, m_we;
  logic [15:0]  m_err_count;
  state_e       m_state;

  logic         o_req_ready, o_resp_valid, o_resp_err;
  logic [31:0]  o_resp_rdata, o_local_addr, o_local_wdata;
  logic [3:0]   o_cs, o_we;
  logic [15:0]  o_err_count;
  state_e       o_state;

  logic         mon_ready, mon_resp_valid, mon_resp_err;
  logic [31:0]  mon_rdata, mon_local_addr, mon_local_wdata;
  logic [3:0]   mon_cs, mon_we;
  logic [15:0]  mon_err_count;

  logic [31:0]  exp_q[$];
  logic [15:0]  err_exp[2];
  int           n_total = 0;
  int           n_pass  = 0;
  vec_t         vecs[12];

  // clock / reset
  always #5 clk = ~clk;

  addr_window_decoder dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid & ~use_ov), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .req_ready (m_req_ready), .resp_valid (m_resp_valid),
    .resp_rdata (m_resp_rdata), .resp_err (m_resp_err),
    .cs (m_cs), .we (m_we), .local_addr (m_local_addr),
    .local_wdata (m_local_wdata), .region_rdata (region_rdata),
    .err_count (m_err_count), .dbg_state (m_state)
  );

  addr_window_decoder #(
    .NUM_REGIONS  (4),
    .ADDR_W       (32),
    .DATA_W       (32),
    .REGION_BASE  ({32'h1, 32'h800, 32'h1, 32'h0}),
    .REGION_LIMIT ({32'h0, 32'h8FF, 32'h0, 32'hFFF}),
    .REGION_WAIT  (16'h0000)
  ) dut_ov (
    .clk (clk), .rst (rst),
    .req_valid (req_valid & use_ov), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .req_ready (o_req_ready), .resp_valid (o_resp_valid),
    .resp_rdata (o_resp_rdata), .resp_err (o_resp_err),
    .cs (o_cs), .we (o_we), .local_addr (o_local_addr),
    .local_wdata (o_local_wdata), .region_rdata (region_rdata),
    .err_count (o_err_count), .dbg_state (o_state)
  );

  always_comb begin
    mon_ready       = use_ov ? o_req_ready   : m_req_ready;
    mon_resp_valid  = use_ov ? o_resp_valid  : m_resp_valid;
    mon_resp_err    = use_ov ? o_resp_err    : m_resp_err;
    mon_rdata       = use_ov ? o_resp_rdata  : m_resp_rdata;
    mon_local_addr  = use_ov ? o_local_addr  : m_local_addr;
    mon_local_wdata = use_ov ? o_local_wdata : m_local_wdata;
    mon_cs          = use_ov ? o_cs          : m_cs;
    mon_we          = use_ov ? o_we          : m_we;
    mon_err_count   = use_ov ? o_err_count   : m_err_count;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_state();
    chk("rst_cs", 32'(m_cs), 32'h0);
    chk("rst_we", 32'(m_we), 32'h0);
    chk("rst_local_addr", m_local_addr, 32'h0);
    chk("rst_local_wdata", m_local_wdata, 32'h0);
    chk("rst_resp_valid", 32'(m_resp_valid), 32'h0);
    chk("rst_resp_rdata", m_resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(m_resp_err), 32'h0);
    chk("rst_err_count", 32'(m_err_count), 32'h0);
    chk("rst_req_ready", 32'(m_req_ready), 32'h1);
    chk("rst_state", 32'(m_state), 32'(IDLE));
    chk("rst_ov_ready", 32'(o_req_ready), 32'h1);
  endtask

  // driver + scoreboard for one table record
  task automatic run_vec(input vec_t v);
    int          cyc, cs_cyc, we_cyc, guard;
    logic [3:0]  s_cs, s_we;
    logic [31:0] s_la, s_wd, exp_rd;
    use_ov = v.ov;
    guard  = 0;
    @(negedge clk);
    while (!mon_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", 32'(mon_ready), 32'h1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    exp_q.push_back(v.exp_rdata);
    if (v.exp_err && err_exp[v.ov] != 16'hFFFF) err_exp[v.ov]++;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    s_cs = mon_cs; s_we = mon_we; s_la = mon_local_addr; s_wd = mon_local_wdata;
    cyc = 1; cs_cyc = 0; we_cyc = 0;
    while (!mon_resp_valid && cyc < 40) begin
      if (mon_cs != '0) cs_cyc++;
      if (mon_we != '0) we_cyc++;
      @(negedge clk);
      cyc++;
    end
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    chk("latency", 32'(cyc), 32'(v.exp_lat));
    chk("cs_cycle1", 32'(s_cs), 32'(v.exp_cs));
    chk("we_cycle1", 32'(s_we), v.we ? 32'(v.exp_cs) : 32'h0);
    if (!v.exp_err) chk("local_addr", s_la, v.exp_local);
    if (!v.exp_err && v.we) chk("local_wdata", s_wd, v.wdata);
    chk("cs_cycles", 32'(cs_cyc), v.exp_err ? 32'h0 : 32'(v.exp_lat - 1));
    chk("we_cycles", 32'(we_cyc), (v.we && !v.exp_err) ? 32'h1 : 32'h0);
    chk("resp_err", 32'(mon_resp_err), 32'(v.exp_err));
    chk("resp_rdata", mon_rdata, exp_rd);
    chk("cs_at_resp", 32'(mon_cs), 32'h0);
    chk("err_count", 32'(mon_err_count), 32'(err_exp[v.ov]));
    @(negedge clk);
    chk("resp_pulse_end", 32'(mon_resp_valid), 32'h0);
    chk("rdata_cleared", mon_rdata, 32'h0);
    chk("ready_after", 32'(mon_ready), 32'h1);
  endtask

  initial begin
    vec_t sv;
    int   seen;
    vecs[0]  = '{1'b0, 1'b0, 32'h780,  32'h0,         4'b0001, 32'h0,   1'b0, 2, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 1'b1, 32'hB7F,  32'h1234_5678, 4'b0001, 32'h3FF, 1'b0, 2, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'hB80,  32'h0,         4'b0010, 32'h0,   1'b0, 4, 32'hCAFE_F00D};
    vecs[3]  = '{1'b0, 1'b0, 32'hB8F,  32'h0,         4'b0010, 32'hF,   1'b0, 4, 32'hCAFE_F00D};
    vecs[4]  = '{1'b0, 1'b1, 32'hB85,  32'h0BAD_C0DE, 4'b0010, 32'h5,   1'b0, 4, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 32'h77F,  32'h0,         4'b0000, 32'h0,   1'b1, 1, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'hB90,  32'h0,         4'b0000, 32'h0,   1'b1, 1, 32'h0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,    32'h0,         4'b0100, 32'h0,   1'b0, 2, 32'hA5A5_0002};
    vecs[8]  = '{1'b0, 1'b1, 32'h1,    32'h5555_AAAA, 4'b0000, 32'h0,   1'b1, 1, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h800,  32'h0,         4'b0001, 32'h800, 1'b0, 2, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 1'b1, 32'h8FF,  32'h7777_1111, 4'b0001, 32'h8FF, 1'b0, 2, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h1000, 32'h0,         4'b0000, 32'h0,   1'b1, 1, 32'h0};
    err_exp[0] = '0;
    err_exp[1] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // err_count saturation from a preloaded near-full value
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    @(negedge clk);
    release dut.err_count;
    err_exp[0] = 16'hFFFE;
    sv = vecs[5];
    run_vec(sv);
    chk("err_sat_reach", 32'(m_err_count), 32'h0000_FFFF);
    sv = vecs[6];
    run_vec(sv);
    chk("err_sat_hold", 32'(m_err_count), 32'h0000_FFFF);

    // reset in the middle of a waited region1 read
    use_ov = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hB80;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_access", 32'(m_state), 32'(ACCESS));
    chk("abort_cs", 32'(m_cs), 32'h2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    err_exp[0] = '0;
    err_exp[1] = '0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_resp_valid) seen = 1;
    end
    chk("abort_no_resp", 32'(seen), 32'h0);

    // request held during RESP must wait for IDLE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h77F;
    @(posedge clk);
    @(negedge clk);
    err_exp[0]++;
    chk("resp_phase_valid", 32'(m_resp_valid), 32'h1);
    chk("resp_phase_err", 32'(m_resp_err), 32'h1);
    chk("resp_phase_ready", 32'(m_req_ready), 32'h0);
    req_addr = 32'h780;
    @(posedge clk);
    @(negedge clk);
    chk("held_ready_idle", 32'(m_req_ready), 32'h1);
    chk("held_not_taken", 32'(m_cs), 32'h0);
    chk("held_resp_low", 32'(m_resp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held_taken_cs", 32'(m_cs), 32'h1);
    chk("held_local_addr", m_local_addr, 32'h0);
    @(negedge clk);
    chk("held_resp_valid", 32'(m_resp_valid), 32'h1);
    chk("held_resp_rdata", m_resp_rdata, 32'hDEAD_BEEF);
    chk("held_err_count", 32'(m_err_count), 32'(err_exp[0]));

    // overlapping-window instance
    for (int i = 9; i < 12; i++) run_vec(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/addr_window_decoder.md
Name: addr_window_decoder

Overview:
- Parametrised bus-side address decoder between the CPU data-memory port and up to NUM_REGIONS memory/peripheral slaves.
- Decodes each request against per-region inclusive [base, limit] windows and drives a one-hot chip select, a gated write enable and a region-relative address.
- Inserts per-region wait states and returns read data through a valid handshake.
- Reports unmapped accesses as errors and counts them.

Parameters:
- NUM_REGIONS, 4, number of decoded windows (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- REGION_BASE, {0x0,0x0,0xB80,0x780} packed NUM_REGIONS*ADDR_W, inclusive low bound per region; region 0 is the LSB slice.
- REGION_LIMIT, {0x0,0x0,0xB8F,0xB7F} packed NUM_REGIONS*ADDR_W, inclusive high bound per region.
- REGION_WAIT, {0,0,2,0} packed NUM_REGIONS*4, extra wait cycles per region (0..15).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  CPU request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address from ALU result
- req_wdata  in  DATA_W  write data
- req_ready  out  1  decoder can accept a request (high only in IDLE)
- resp_valid  out  1  one-cycle pulse: access finished
- resp_rdata  out  DATA_W  read data (0 on writes and errors)
- resp_err  out  1  qualifies resp_valid: address unmapped
- cs  out  NUM_REGIONS  one-hot region chip select
- we  out  NUM_REGIONS  gated write enable per region
- local_addr  out  ADDR_W  req_addr minus the selected region's base
- local_wdata  out  DATA_W  registered write data
- region_rdata  in  NUM_REGIONS*DATA_W  read data from each slave
- err_count  out  16  saturating count of unmapped requests

Behaviour:
- Reset: synchronous on rst high at a clk edge. State IDLE. cs, we, local_addr, local_wdata, resp_valid, resp_rdata, resp_err and err_count are all 0; req_ready is 1. A reset during ACCESS or RESP aborts the access and drops any pending response.
- Hit rule: a region k matches when REGION_BASE[k] <= req_addr <= REGION_LIMIT[k], unsigned and inclusive at both ends. A region with base > limit is disabled and never matches. If windows overlap, the lowest index wins.
- State IDLE (req_ready = 1): on req_valid at a clk edge:
  - On a hit in region k, register cs = 1<<k, we = req_we<<k, local_addr = req_addr - REGION_BASE[k] (ADDR_W wide, never underflows), local_wdata = req_wdata. Load wait counter with REGION_WAIT[k]. Next state ACCESS.
  - On a miss, cs and we stay 0 and err_count increments, saturating at 0xFFFF. Next state RESP with err flag set.
- State ACCESS:
  - cs and local_addr are held.
  - we is high only in the first ACCESS cycle, so a slave sees exactly one write strobe; it clears afterwards.
  - While counter != 0, decrement it.
  - When counter == 0, capture region_rdata[k] into resp_rdata (0 for writes), clear cs, and go to RESP.
- State RESP:
  - resp_valid = 1 for exactly one cycle; resp_err = 1 only for a miss.
  - Next state IDLE. resp_valid, resp_err and resp_rdata return to 0 on the following cycle.
- Latency, with request accepted at edge 0:
  - Hit with W wait cycles: ACCESS lasts W+1 cycles and resp_valid is high in cycle W+2.
  - Miss: resp_valid is high in cycle 1.
- No back-to-back acceptance: a new request can be accepted at the earliest in the cycle after RESP.
- req_valid while req_ready = 0 is ignored. The CPU holds its request until it sees req_ready.
- err_count is never cleared except by rst.

Decomposition:
- Shared package addr_map_pkg:
  - state enum {IDLE, ACCESS, RESP}
  - the default region base/limit/wait constants, so the CPU top and the memory map stay consistent
  - WAIT_W = 4
- One natural sub-module: addr_region_match. It is purely combinational: per-region range compare plus a priority encoder. Outputs are hit, a one-hot selection and the region index. It is instantiated once and holds all compares, so the FSM file contains only sequencing.

Test Plan:
- Read 0x780 with region0 rdata 0xDEADBEEF -> cs = 0001, local_addr = 0, resp_valid in cycle 2 with rdata 0xDEADBEEF, err = 0.
- Write 0xB7F with data 0x12345678 -> we = 0001 for exactly one cycle, local_addr = 0x3FF, resp_valid in cycle 2 with rdata 0.
- Read 0xB80, where region1 has wait 2 -> cs = 0010 held for 3 cycles, local_addr = 0, resp_valid in cycle 4.
- Read 0x77F and 0xB90 -> no cs, resp_valid and resp_err in cycle 1, err_count goes 1 then 2. Force err_count to 0xFFFF, then miss again -> stays 0xFFFF.
- Assert rst during the ACCESS of a region1 read -> on the next edge all outputs are 0, req_ready = 1, and no resp_valid ever appears for the aborted access.
- Overlapping parameter set (region0 0x0-0xFFF, region2 0x800-0x8FF), read 0x800 -> cs = 0001 (lowest index wins). Request asserted during RESP -> not accepted until IDLE.
